// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port tagged-word memory between NUM_REQ requesters.
// Registered memory command, optional grant lock, and read responses routed back through a latency-matched ID pipeline.
module mem_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ-1:0]        REQ_WE,
  input  logic [NUM_REQ-1:0]        REQ_LOCK,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]        REQ_READY,
  output logic [NUM_REQ-1:0]        RSP_VALID,
  output logic [DATA_W-1:0]         RSP_DATA,
  output logic [ADDR_W-1:0]         MEM_ADDR,
  output logic                      MEM_WE,
  output logic [DATA_W-1:0]         MEM_WDATA,
  input  logic [DATA_W-1:0]         MEM_RDATA
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PIPE_D = 1 + MEM_LAT;

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic               r_locked;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_we;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [NUM_REQ-1:0] r_id_pipe [PIPE_D];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gidx;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_we;
  logic               w_lock_clear;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    int unsigned t;
    t = 32'(i) + 1;
    return IDX_W'(t % NUM_REQ);
  endfunction

  // While locked only the owner is eligible; otherwise scan from r_ptr and take the first valid requester.
  always_comb begin
    int unsigned v_idx;
    logic        v_hit;
    w_grant = '0;
    w_gidx  = '0;
    v_idx   = 0;
    v_hit   = 1'b0;
    if (RST_N) begin
      if (r_locked) begin
        if (REQ_VALID[r_owner]) begin
          w_grant[r_owner] = 1'b1;
          w_gidx           = r_owner;
        end
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          v_idx = (32'(r_ptr) + k) % NUM_REQ;
          if (!v_hit && REQ_VALID[v_idx]) begin
            v_hit          = 1'b1;
            w_grant[v_idx] = 1'b1;
            w_gidx         = IDX_W'(v_idx);
          end
        end
      end
    end
  end

  assign w_accept    = |w_grant;
  assign w_sel_addr  = REQ_ADDR[w_gidx*ADDR_W +: ADDR_W];
  assign w_sel_wdata = REQ_WDATA[w_gidx*DATA_W +: DATA_W];
  assign w_sel_we    = REQ_WE[w_gidx];
  // An owner that goes idle, or issues an unlocked transaction, releases the port.
  assign w_lock_clear = r_locked && (!REQ_VALID[r_owner] || !REQ_LOCK[r_owner]);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_locked <= 1'b0;
    end else if (r_locked) begin
      if (w_lock_clear) begin
        r_locked <= 1'b0;
        r_ptr    <= next_idx(r_owner);
      end
    end else if (w_accept) begin
      r_ptr <= next_idx(w_gidx);
      if (REQ_LOCK[w_gidx]) begin
        r_locked <= 1'b1;
        r_owner  <= w_gidx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_mem_addr  <= w_sel_addr;
      r_mem_we    <= w_sel_we;
      r_mem_wdata <= w_sel_wdata;
    end else begin
      r_mem_we    <= 1'b0;
    end
  end

  // Stage 0 lines up with MEM_ADDR; the last stage lines up with MEM_RDATA being valid.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < PIPE_D; k++) begin
        r_id_pipe[k] <= '0;
      end
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_id_pipe[0] <= (w_accept && !w_sel_we) ? w_grant : '0;
      for (int unsigned k = 1; k < PIPE_D; k++) begin
        r_id_pipe[k] <= r_id_pipe[k-1];
      end
      r_rsp_valid <= r_id_pipe[PIPE_D-1];
      if (|r_id_pipe[PIPE_D-1]) begin
        r_rsp_data <= MEM_RDATA;
      end
    end
  end

  assign REQ_READY = w_grant;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WE    = r_mem_we;
  assign MEM_WDATA = r_mem_wdata;

endmodule
